c_credit_sched: RTL and testbench
=================================

# c_credit_sched

Credit-based round-robin scheduler sharing one downstream FIFO among `num_ports` requesters. It tracks free downstream entries by instantiating `c_fifo_tracker`, issues at most one registered one-hot grant per cycle while credits remain, and accepts credit returns. A flush FSM stops new grants until all credits are home.

## Interface
- `num_ports`, 4: number of requesters (≥2).
- `depth`, 8: downstream FIFO entries, which is also the initial credit count (≥1).
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; asserted at 0.
- `active` input 1: register enable; when 0, all state holds.
- `req` input [0:num_ports-1]: per-port request level, held until granted.
- `cred_ret` input 1: one credit returned (downstream pop) this cycle.
- `flush` input 1: request a drain, sampled in RUN.
- `gnt` output [0:num_ports-1]: registered one-hot grant pulse; each pulse consumes one credit.
- `free` output clogb(depth+1): current free credit count.
- `flush_done` output 1: one-cycle pulse when a drain completes.
- `errors` output [0:2]: {credit underflow, credit overflow, req-drop}.

## Operation
- Eligibility: a port is eligible when `req` is set, state is RUN, and a credit is available. A credit is available when the tracker is not full.
- Selection: round-robin from the pointer `rr_q`. The first eligible port at or after `rr_q`, with wrap-around, wins and sets `gnt_s`.
- On a grant to port p: `rr_q` moves to (p+1) mod num_ports, so the winner has lowest priority next. `rr_q` is unchanged when there is no grant.
- Tracker hookup: `push = |gnt_s`, `pop = cred_ret`.
- Credit arithmetic:
  - push with pop: free unchanged.
  - push only: free − 1.
  - pop only: free + 1.
- Error flags (combinational from the current cycle; they do not stop operation):
  - `errors[0]` (underflow): a grant with free==0. This is unreachable by design and acts as an assertion hook.
  - `errors[1]` (overflow): `cred_ret` with free==depth. The count saturates at depth.
  - `errors[2]` (req-drop): a port drops `req` while it is the pending highest-priority eligible port.
- FSM, RUN/FLUSH:
  - RUN → FLUSH on `flush`. A grant already selected in that cycle still issues.
  - FLUSH makes no ports eligible.
  - FLUSH → RUN when free==depth, i.e. the tracker is empty. `flush_done` pulses in the cycle after the transition edge.
  - A flush raised while free==depth still enters FLUSH for exactly one cycle.
  - `flush` asserted during FLUSH is ignored.

## Timing
- Reset values: `gnt`=0, `free`=depth, `rr_q`=0 (port 0 highest priority), state RUN, `flush_done`=0.
- `errors` are combinational: 0 at reset with idle inputs.
- Latency: `req` in cycle t produces `gnt` in cycle t+1; `free` reflects that grant in cycle t+1.
- `cred_ret` in cycle t makes the credit usable for a selection in t+1, giving `gnt` at t+2.
- Sustained throughput: one grant per cycle while credits last.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight grant is lost and credits are reinitialised to depth. Downstream must be reset together with this block.

## Configuration
- `C_CREDIT_SCHED_BYPASS_EN` defined: when free==0 and `cred_ret` is high in the same cycle, the returning credit counts as available. A grant may then be selected that cycle; the tracker sees push and pop together and free stays 0.
- Undefined: when free==0, grants are blocked even if `cred_ret` is high. The credit becomes usable one cycle later.

## Structure
- Shared package/header: FSM state encodings `SCHED_STATE_RUN` and `SCHED_STATE_FLUSH`, the errors bit indices, and the existing `clogb` function.
- Sub-modules:
  - New: `c_credit_rr_select`, combinational round-robin picker with inputs eligible vector and `rr_q`, outputs one-hot `gnt_s` and next pointer.
  - Reused: existing `c_fifo_tracker`, with `reset_type` set to async.
  - Reused: `c_dff` for `gnt`, `rr_q` and state.

## Test plan
- Reset release with `req`=4'b1111, no returns, depth=8 → grants to ports 0,1,2,3,0,1,2,3 on consecutive cycles; `free` falls 8→0; `gnt`=0 from the ninth cycle on.
- Credits exhausted with one `cred_ret` pulse at cycle t:
  - Macro undefined → exactly one grant at t+2.
  - Macro defined → exactly one grant at t+1; `free` stays 0.
- `req`=4'b0100 only, ample credits → `gnt` to port 2 every cycle; `rr_q` stays 3 after each grant.
- `flush` with free=5 → no grants while in FLUSH; 3 `cred_ret` pulses bring free to 8; `flush_done` pulses once; grants resume the next cycle.
- `cred_ret` with free==depth → `errors[1]`=1 that cycle; `free` stays at depth.
- Reset asserted mid-burst with free=2 → `gnt`=0 and free=8 immediately; `rr_q`=0 after release.

Source files
------------

// File: rtl/c_credit_sched_pkg.sv
// Shared definitions for the credit scheduler: FSM encodings, error bit
// indices, tracker reset styles and the clogb width helper.
package c_credit_sched_pkg;

  typedef enum logic [0:0] {
    SCHED_STATE_RUN   = 1'b0,
    SCHED_STATE_FLUSH = 1'b1
  } sched_state_t;

  // Bit positions inside the errors vector.
  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;
  localparam int ERR_REQ_DROP  = 2;

  // Reset styles understood by c_fifo_tracker.
  localparam int RESET_TYPE_ASYNC = 0;
  localparam int RESET_TYPE_SYNC  = 1;

  // Number of bits needed to encode the values 0 .. value-1.
  function automatic int clogb(input int value);
    int r;
    int one;
    r   = 0;
    one = 1;
    while ((one << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/c_credit_rr_select.sv
// Combinational round-robin picker: first set bit at or after rr_q, with
// wrap-around. rr_next points one past the winner, or stays at rr_q.
module c_credit_rr_select
  import c_credit_sched_pkg::*;
#(
  parameter int  num_ports = 4,
  localparam int PW        = clogb(num_ports)
) (
  input  logic [0:num_ports-1] eligible,
  input  logic [PW-1:0]        rr_q,
  output logic [0:num_ports-1] gnt_s,
  output logic [PW-1:0]        rr_next
);

  int   idx;
  logic found;

  // Scan ports starting at the pointer and keep only the first hit.
  always_comb begin
    gnt_s   = '0;
    rr_next = rr_q;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < num_ports; i++) begin
      idx = (int'(rr_q) + i) % num_ports;
      if (!found && eligible[idx]) begin
        gnt_s[idx] = 1'b1;
        rr_next    = PW'((idx + 1) % num_ports);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/c_dff.sv
// Enabled register with asynchronous active-low reset to a parameterised value.
module c_dff #(
  parameter int               width       = 1,
  parameter logic [width-1:0] reset_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  // Load d on enabled edges, return to reset_value as soon as reset falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= reset_value;
    end else if (active) begin
      q <= d;
    end
  end

endmodule

// File: rtl/c_fifo_tracker.sv
// Free-entry counter for a downstream FIFO. push consumes an entry, pop
// returns one; the count saturates at 0 and at depth.
module c_fifo_tracker
  import c_credit_sched_pkg::*;
#(
  parameter int depth      = 8,
  parameter int reset_type = RESET_TYPE_ASYNC,
  localparam int FW        = clogb(depth + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          active,
  input  logic          push,
  input  logic          pop,
  output logic [FW-1:0] free,
  output logic          full,
  output logic          empty
);

  logic [FW-1:0] free_next;

  // Next free count: push and pop together cancel, otherwise step by one.
  always_comb begin
    free_next = free;
    case ({push, pop})
      2'b10: begin
        if (free != FW'(0)) free_next = free - FW'(1);
        else                free_next = free;
      end
      2'b01: begin
        if (free != FW'(depth)) free_next = free + FW'(1);
        else                    free_next = free;
      end
      default: free_next = free;
    endcase
  end

  generate
    if (reset_type == RESET_TYPE_ASYNC) begin : g_async
      // Free count register, reinitialised to depth immediately on reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)      free <= FW'(depth);
        else if (active) free <= free_next;
      end
    end else begin : g_sync
      // Free count register, reinitialised to depth on the next edge.
      always_ff @(posedge clk) begin
        if (!reset)      free <= FW'(depth);
        else if (active) free <= free_next;
      end
    end
  endgenerate

  assign full  = (free == FW'(0));
  assign empty = (free == FW'(depth));

endmodule

// File: rtl/c_credit_sched.sv
// Credit-based round-robin scheduler in front of one shared downstream FIFO.
// Optional feature macro: C_CREDIT_SCHED_BYPASS_EN -- a credit returning
// while free==0 may be granted in the same cycle (push and pop cancel).
module c_credit_sched
  import c_credit_sched_pkg::*;
#(
  parameter int num_ports = 4,
  parameter int depth     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      active,
  input  logic [0:num_ports-1]      req,
  input  logic                      cred_ret,
  input  logic                      flush,
  output logic [0:num_ports-1]      gnt,
  output logic [clogb(depth+1)-1:0] free,
  output logic                      flush_done,
  output logic [0:2]                errors
);

  localparam int PW = clogb(num_ports);

  logic [0:0]           state_q;
  sched_state_t         state;
  sched_state_t         state_next;
  logic                 run;
  logic                 flush_done_d;
  logic [PW-1:0]        rr_q;
  logic [PW-1:0]        rr_d;
  logic [PW-1:0]        pick_next;
  logic [0:num_ports-1] pick;
  logic [0:num_ports-1] gnt_s;
  logic [0:num_ports-1] pend_q;
  logic [0:num_ports-1] pend_d;
  logic                 grant_any;
  logic                 avail;
  logic                 full;
  logic                 empty;

  assign state = sched_state_t'(state_q);

  // Eligibility is req gated by one global condition (RUN and a credit), so
  // picking over req and gating afterwards equals picking over eligible.
  c_credit_rr_select #(.num_ports(num_ports)) u_pick (
    .eligible (req),
    .rr_q     (rr_q),
    .gnt_s    (pick),
    .rr_next  (pick_next)
  );

`ifdef C_CREDIT_SCHED_BYPASS_EN
  assign avail = ~full | cred_ret;
`else
  assign avail = ~full;
`endif

  assign gnt_s     = pick & {num_ports{run & avail}};
  assign grant_any = |gnt_s;
  assign rr_d      = grant_any ? pick_next : rr_q;
  // The top requester that was not served this cycle stays pending and must
  // keep its request up until granted.
  assign pend_d    = grant_any ? '0 : pick;

  c_fifo_tracker #(.depth(depth), .reset_type(RESET_TYPE_ASYNC)) u_tracker (
    .clk    (clk),
    .reset  (reset),
    .active (active),
    .push   (grant_any),
    .pop    (cred_ret),
    .free   (free),
    .full   (full),
    .empty  (empty)
  );

  c_dff #(.width(num_ports), .reset_value('0)) u_gnt_reg (
    .clk (clk), .reset (reset), .active (active), .d (gnt_s), .q (gnt)
  );

  c_dff #(.width(PW), .reset_value('0)) u_rr_reg (
    .clk (clk), .reset (reset), .active (active), .d (rr_d), .q (rr_q)
  );

  c_dff #(.width(num_ports), .reset_value('0)) u_pend_reg (
    .clk (clk), .reset (reset), .active (active), .d (pend_d), .q (pend_q)
  );

  // FSM state register.
  c_dff #(.width(1), .reset_value(SCHED_STATE_RUN)) u_state_reg (
    .clk (clk), .reset (reset), .active (active), .d (state_next), .q (state_q)
  );

  c_dff #(.width(1), .reset_value(1'b0)) u_done_reg (
    .clk (clk), .reset (reset), .active (active), .d (flush_done_d), .q (flush_done)
  );

  // FSM next state: enter FLUSH on request, leave once every credit is home.
  always_comb begin
    state_next = state;
    case (state)
      SCHED_STATE_RUN: begin
        if (flush) state_next = SCHED_STATE_FLUSH;
        else       state_next = SCHED_STATE_RUN;
      end
      SCHED_STATE_FLUSH: begin
        if (empty) state_next = SCHED_STATE_RUN;
        else       state_next = SCHED_STATE_FLUSH;
      end
      default: state_next = SCHED_STATE_RUN;
    endcase
  end

  // FSM outputs: grant enable in RUN, drain-complete strobe on FLUSH exit.
  always_comb begin
    run          = 1'b0;
    flush_done_d = 1'b0;
    case (state)
      SCHED_STATE_RUN:   run          = 1'b1;
      SCHED_STATE_FLUSH: flush_done_d = empty;
      default: begin
        run          = 1'b0;
        flush_done_d = 1'b0;
      end
    endcase
  end

  // Error flags from the current cycle; informational only.
  always_comb begin
    errors                = 3'b000;
    errors[ERR_UNDERFLOW] = grant_any & full & ~cred_ret;
    errors[ERR_OVERFLOW]  = cred_ret & empty;
    errors[ERR_REQ_DROP]  = |(pend_q & ~req);
  end

endmodule

// File: tb/tb_c_credit_sched.sv
// Self-checking bench for c_credit_sched (4 ports, depth 8). An integer model
// of the scheduling rules predicts every output each cycle; hand-computed
// literals pin the main scenarios. Honours C_CREDIT_SCHED_BYPASS_EN.
module tb_c_credit_sched;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         active;
  logic [0:N-1] req;
  logic         cred_ret;
  logic         flush;
  logic [0:N-1] gnt;
  logic [3:0]   free;
  logic         flush_done;
  logic [0:2]   errors;

  int checks   = 0;
  int failures = 0;

  // Model state
  int m_free, m_rr, m_pend, m_gnt;
  bit m_flush, m_fd;

  // Observations for literal checks
  int last_gnt, last_drop, last_over, last_fd, fd_count;

  c_credit_sched #(.num_ports(N), .depth(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .req        (req),
    .cred_ret   (cred_ret),
    .flush      (flush),
    .gnt        (gnt),
    .free       (free),
    .flush_done (flush_done),
    .errors     (errors)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [0:N-1] v);
    int r = -1;
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = i;
        c++;
      end
    end
    if (c > 1) r = -2;
    return r;
  endfunction

  task automatic model_reset();
    m_free  = DEPTH;
    m_rr    = 0;
    m_pend  = -1;
    m_gnt   = -1;
    m_flush = 1'b0;
    m_fd    = 1'b0;
  endtask

  // Assert reset, check reset state without a clock edge, release at negedge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    chk({tag, "_gnt"}, onehot_idx(gnt), -1);
    chk({tag, "_free"}, int'(free), DEPTH);
    chk({tag, "_flush_done"}, int'(flush_done), 0);
    chk({tag, "_rr"}, int'(dut.rr_q), 0);
    chk({tag, "_errors"}, int'(errors), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive at negedge, check combinational flags, advance the model,
  // check registered outputs just after the rising edge, return at negedge.
  // Bit i of m is the request of port i.
  task automatic step(input logic [3:0] m, input logic cr, input logic fl,
                      input logic act = 1'b1);
    int  top, p, nf, k;
    bit  av, drop, over, under;
    for (int i = 0; i < N; i++) req[i] = m[i];
    cred_ret = cr;
    flush    = fl;
    active   = act;
    #1;
    top = -1;
    for (int i = 0; i < N; i++) begin
      k = (m_rr + i) % N;
      if (top < 0 && m[k]) top = k;
    end
    av = (m_free > 0);
`ifdef C_CREDIT_SCHED_BYPASS_EN
    av = av || cr;
`endif
    p     = (!m_flush && av) ? top : -1;
    drop  = (m_pend >= 0) && !m[m_pend];
    over  = cr && (m_free == DEPTH);
    under = (p >= 0) && (m_free == 0) && !cr;
    chk("err_underflow", int'(errors[0]), int'(under));
    chk("err_overflow", int'(errors[1]), int'(over));
    chk("err_req_drop", int'(errors[2]), int'(drop));
    last_drop = int'(errors[2]);
    last_over = int'(errors[1]);
    if (act) begin
      nf = m_free;
      if (p >= 0 && !cr) nf = nf - 1;
      else if (p < 0 && cr && nf < DEPTH) nf = nf + 1;
      m_fd = m_flush && (m_free == DEPTH);
      if (!m_flush) m_flush = fl;
      else if (m_free == DEPTH) m_flush = 1'b0;
      if (p >= 0) m_rr = (p + 1) % N;
      m_pend = (p >= 0) ? -1 : top;
      m_free = nf;
      m_gnt  = p;
    end
    @(posedge clk);
    #1;
    chk("gnt", onehot_idx(gnt), m_gnt);
    chk("free", int'(free), m_free);
    chk("flush_done", int'(flush_done), int'(m_fd));
    chk("rr_q", int'(dut.rr_q), m_rr);
    last_gnt = onehot_idx(gnt);
    last_fd  = int'(flush_done);
    fd_count += int'(flush_done);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    active   = 1'b1;
    req      = '0;
    cred_ret = 1'b0;
    flush    = 1'b0;
    fd_count = 0;
    #2;
    do_reset("rst0");

    // Burst with all ports requesting: 0,1,2,3,0,1,2,3 then credits run out.
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("t1_port", last_gnt, i % 4);
      chk("t1_free", int'(free), 7 - i);
    end
    step(4'b1111, 1'b0, 1'b0);
    chk("t1_gnt_none9", last_gnt, -1);
    step(4'b1111, 1'b0, 1'b0);
    chk("t1_gnt_none10", last_gnt, -1);
    chk("t1_free0", int'(free), 0);

    // One credit returned while exhausted.
    step(4'b1111, 1'b1, 1'b0);
`ifdef C_CREDIT_SCHED_BYPASS_EN
    chk("t2_gnt_t1", last_gnt, 0);
    chk("t2_free_t1", int'(free), 0);
    step(4'b1111, 1'b0, 1'b0);
    chk("t2_gnt_t2", last_gnt, -1);
`else
    chk("t2_gnt_t1", last_gnt, -1);
    chk("t2_free_t1", int'(free), 1);
    step(4'b1111, 1'b0, 1'b0);
    chk("t2_gnt_t2", last_gnt, 0);
`endif
    step(4'b1111, 1'b0, 1'b0);
    chk("t2_gnt_t3", last_gnt, -1);
    chk("t2_free_t3", int'(free), 0);
    // Port 1 is pending top priority; dropping all requests flags req-drop.
    step(4'b0000, 1'b0, 1'b0);
    chk("t2_req_drop", last_drop, 1);

    // Single requester on port 2.
    do_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      chk("t3_port", last_gnt, 2);
      chk("t3_rr", int'(dut.rr_q), 3);
    end
    chk("t3_free", int'(free), 4);

    // Flush from free=5 with requests held, three returns drain it.
    step(4'b0000, 1'b1, 1'b0);
    chk("t4_free5", int'(free), 5);
    fd_count = 0;
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    chk("t4_gnt_s1", last_gnt, -1);
    step(4'b1111, 1'b0, 1'b1);
    chk("t4_gnt_s2", last_gnt, -1);
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("t4_free8", int'(free), 8);
    chk("t4_gnt_s4", last_gnt, -1);
    step(4'b1111, 1'b0, 1'b0);
    chk("t4_gnt_s5", last_gnt, -1);
    chk("t4_done", last_fd, 1);
    step(4'b1111, 1'b0, 1'b0);
    chk("t4_resume", last_gnt, 3);
    chk("t4_done_count", fd_count, 1);

    // Flush while already empty: one FLUSH cycle, then grants again.
    do_reset("rst2");
    step(4'b0000, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    chk("t5_gnt_flush", last_gnt, -1);
    chk("t5_done", last_fd, 1);
    step(4'b1111, 1'b0, 1'b0);
    chk("t5_resume", last_gnt, 0);

    // Return with every credit home: overflow flag, count saturates.
    do_reset("rst3");
    step(4'b0000, 1'b1, 1'b0);
    chk("t6_overflow", last_over, 1);
    chk("t6_free", int'(free), 8);

    // Hold with active low: nothing moves.
    step(4'b0010, 1'b0, 1'b0);
    chk("t7_port1", last_gnt, 1);
    step(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("t7_hold_gnt", last_gnt, 1);
    chk("t7_hold_free", int'(free), 7);

    // Reset in the middle of a burst with free=2.
    do_reset("rst4");
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b0, 1'b0);
    chk("t8_free2", int'(free), 2);
    do_reset("rst_mid");
    step(4'b1111, 1'b0, 1'b0);
    chk("t8_after_port", last_gnt, 0);
    chk("t8_after_free", int'(free), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
